// File: rtl/ecall_io_unit.sv
// ecall_io_unit: ecall service unit (print, read switches on button press, exit) driving a scanned 7-seg display.
// Define ECALL_DEC_DISPLAY_EN to show prints as unsigned decimal (double-dabble) instead of hex.
module ecall_io_unit #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 8,
  parameter int DIGITS       = 8,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_DIV     = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecall,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a7,
  input  logic [SW_W-1:0]   switches,
  input  logic              button,
  output logic              ecall_done,
  output logic              ecall_write,
  output logic [DATA_W-1:0] ecall_result,
  output logic              halted,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] seg_sel
);
  localparam int DW  = 4 * DIGITS;
  localparam int DBW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int SCW = $clog2(SCAN_DIV) + 1;
  localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [2:0] {
    IDLE,
    PRINT,
`ifdef ECALL_DEC_DISPLAY_EN
    CONVERT,
`endif
    WAIT_PRESS,
    DONE,
    HALT
  } state_t;
  state_t state, state_nxt;
  logic s1, s2, deb, deb_rise, wr_flag, done_d, accept;
  logic [DBW-1:0] db_cnt;
  logic [DW-1:0] disp;
  logic [SCW-1:0] scan_cnt;
  logic [IW-1:0] idx, nidx;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction
  // deb_rise: the debounced level is about to go 0->1 at this edge (press event)
  assign deb_rise = s2 & ~deb & (db_cnt == DBW'(DEBOUNCE_CYC - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (s2 == deb) db_cnt <= '0;
      else if (db_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
        deb    <= s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
`ifdef ECALL_DEC_DISPLAY_EN
  localparam int CW = $clog2(DATA_W) + 1;
  logic [DATA_W-1:0] bin;
  logic [DW-1:0] bcd, adj, bcd_nxt;
  logic [CW-1:0] cv_cnt;
  logic cv_last;
  assign cv_last = cv_cnt == CW'(DATA_W - 1);
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // higher BCD digits never feed lower ones, so truncating to DIGITS is exact
  assign bcd_nxt = DW'({adj, bin[DATA_W-1]});
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bin    <= '0;
      bcd    <= '0;
      cv_cnt <= '0;
    end else if (state == PRINT) begin
      bin    <= a0;
      bcd    <= '0;
      cv_cnt <= '0;
    end else if (state == CONVERT) begin
      bin    <= bin << 1;
      bcd    <= bcd_nxt;
      cv_cnt <= cv_cnt + 1'b1;
    end
`endif
  // a request still high during or just after the done pulse belongs to the retiring ecall
  assign accept = ecall & ~ecall_done & ~done_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (accept)
          state_nxt = a7 == DATA_W'(1)  ? PRINT :
                      a7 == DATA_W'(5)  ? WAIT_PRESS :
                      a7 == DATA_W'(10) ? HALT : DONE;
`ifdef ECALL_DEC_DISPLAY_EN
      PRINT:      state_nxt = CONVERT;
      CONVERT:    state_nxt = !ecall ? IDLE : cv_last ? DONE : CONVERT;
`else
      PRINT:      state_nxt = DONE;
`endif
      WAIT_PRESS: state_nxt = !ecall ? IDLE : deb_rise ? DONE : WAIT_PRESS;
      DONE:       state_nxt = IDLE;
      HALT:       state_nxt = HALT;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ecall_done   <= 1'b0;
      ecall_write  <= 1'b0;
      ecall_result <= '0;
      halted       <= 1'b0;
      wr_flag      <= 1'b0;
      done_d       <= 1'b0;
      disp         <= '0;
    end else begin
      ecall_done  <= state == DONE;
      ecall_write <= state == DONE && wr_flag;
      done_d      <= ecall_done;
      if (state == DONE) wr_flag <= 1'b0;
      if (state == WAIT_PRESS && ecall && deb_rise) begin
        ecall_result <= DATA_W'(switches);
        wr_flag      <= 1'b1;
      end
      if (state_nxt == HALT) halted <= 1'b1;
`ifdef ECALL_DEC_DISPLAY_EN
      if (state == CONVERT && ecall && cv_last) disp <= bcd_nxt;
`else
      if (state == PRINT) disp <= DW'(a0);
`endif
    end
  // segments are refreshed only on digit change, so display updates never restart the scan
  assign nidx = idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= 8'hFF;
      seg_sel  <= '1;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= nidx;
      seg      <= {1'b1, ~hex7(disp[{nidx, 2'b00} +: 4])};
      seg_sel  <= ~(DIGITS'(1) << nidx);
    end else scan_cnt <= scan_cnt + 1'b1;
endmodule

// File: doc/ecall_io_unit.md
Name: ecall_io_unit

Overview:
- Parametrised environment-call I/O handler for the pipelined RISC-V core.
- Sits beside the ALU in EX and services `ecall` requests using a7 (service code) and a0 (argument).
- Drives a multiplexed seven-segment display, reads a debounced button plus switches, and halts the core on exit.
- Returns a one-cycle done pulse; the pipeline uses this pulse to release its stall and flush the IF/ID buffers.

Parameters:
- DATA_W, 32, register/data width of a0, a7 and result.
- SW_W, 8, switch input width (SW_W <= DATA_W).
- DIGITS, 8, seven-segment digit count (1..8).
- DEBOUNCE_CYC, 1000000, cycles a synchronised button level must be stable to be accepted (>= 2).
- SCAN_DIV, 100000, cycles each digit stays selected during scanning (>= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- ecall  in  1  level request from ID/EX buffer; held until ecall_done.
- a0  in  DATA_W  argument.
- a7  in  DATA_W  service code.
- switches  in  SW_W  raw switch inputs.
- button  in  1  raw push-button, active-high.
- ecall_done  out  1  one-cycle completion pulse.
- ecall_write  out  1  one-cycle pulse; coincident with ecall_done when a result must be written to a0.
- ecall_result  out  DATA_W  result value; valid while ecall_write=1, held otherwise.
- halted  out  1  exit service executed; sticky until reset.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- seg_sel  out  DIGITS  digit enables, active-low one-hot.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; ecall_done=0, ecall_write=0, ecall_result=0, halted=0.
  - Display register=0, scan counter=0, digit index=0.
  - seg=8'hFF, seg_sel=all ones; debounce counter=0, debounced level=0.
- Button path:
  - 2-FF synchroniser feeds the debouncer.
  - The debounced level changes only after DEBOUNCE_CYC consecutive cycles at the new synchronised level.
  - A press event is a 0->1 transition of the debounced level.
- State machine: IDLE, PRINT, CONVERT (macro only), WAIT_PRESS, DONE, HALT.
- IDLE, ecall=1 sampled at an edge:
  - a7==1 -> PRINT.
  - a7==5 -> WAIT_PRESS.
  - a7==10 -> HALT.
  - Any other code -> DONE, with no write.
  - a7 is compared across its full DATA_W bits.
- PRINT:
  - Latch a0 into the display register.
  - Go to DONE (or CONVERT when the macro is enabled).
- WAIT_PRESS:
  - Only a press event occurring after entry completes the read; a button already held at entry must first be released and pressed again.
  - On a press event: ecall_result <= zero-extended switches sampled in that cycle; go to DONE with the write flag set.
  - If ecall drops while waiting (flush): return to IDLE, no done pulse.
- DONE:
  - ecall_done=1 (and ecall_write=1 if the write flag is set) for exactly one cycle.
  - Then IDLE.
  - ecall is ignored in the first cycle after the done pulse.
- HALT:
  - halted=1; ecall_done never asserts.
  - Remains until reset; display keeps scanning.
- Latency, accept edge to ecall_done high:
  - Print (no macro): 2 cycles.
  - Unknown code: 1 cycle.
  - Read: 1 cycle after the press event.
- Display scan:
  - Scan counter counts 0..SCAN_DIV-1, then advances digit index, wrapping DIGITS-1 -> 0.
  - Digit i shows nibble i of the display register in hex (0-F).
  - Digit 0 is rightmost (seg_sel[0]); dp always off.
  - Scanning runs in every state, including HALT.
- Simultaneous events:
  - Reset dominates everything.
  - A press event while not in WAIT_PRESS is discarded.
  - A display update takes effect on the next scan digit without restarting the scan.

Optional Feature:
- Macro: ECALL_DEC_DISPLAY_EN.
- With the macro:
  - PRINT enters CONVERT, an iterative double-dabble over DATA_W cycles.
  - a0 is shown as unsigned decimal, lower DIGITS BCD digits; higher digits are truncated and leading zeros are shown.
  - The display register updates at the end of the conversion, then DONE.
  - Print latency becomes DATA_W+2 cycles.
  - ecall dropping during CONVERT aborts to IDLE; the display is unchanged.
- Without the macro: hex display only; no CONVERT state is synthesised.

Test Plan:
- Reset: assert rst=0 mid-WAIT_PRESS -> state IDLE; seg=8'hFF; seg_sel=8'hFF; all result/done/halted outputs 0.
- Print: a7=1, a0=32'h1234ABCD (SCAN_DIV=4) -> ecall_done pulses 2 cycles after accept with ecall_write=0; scanning digits 0..7 show D,C,B,A,4,3,2,1.
- Read: DEBOUNCE_CYC=4, a7=5, switches=8'hA5:
  - 3-cycle button glitch -> no done.
  - Clean press -> ecall_write=ecall_done=1 for one cycle, ecall_result=32'h000000A5.
- Held button: button already high when a7=5 is accepted -> no done until release and re-press.
- Exit and unknown:
  - a7=10 -> halted=1 permanently, no done.
  - a7=7 -> done after 1 cycle, ecall_write=0.
- Flush / macro: ecall dropped in WAIT_PRESS -> IDLE, no pulse. With ECALL_DEC_DISPLAY_EN, a0=12345678 -> done after 34 cycles, digits show 1,2,3,4,5,6,7,8 (digit 0 = 8).
